pcie_tx_pkt_fifo: RTL and testbench

// - Store-and-forward packet FIFO between the TX arbiter output and the PCIe SS TX AXI-S port.
// - Presents a TLP downstream only once all of its beats are buffered, so TX beats reach the SS

---
 rtl/pcie_tx_pkt_fifo_pkg.sv | 24 ++
 rtl/pcie_tx_pkt_fifo_if.sv | 25 ++
 rtl/pcie_tx_pkt_fifo_mem.sv | 26 ++
 rtl/pcie_tx_pkt_fifo.sv | 153 +++++++++++++++
 tb/tb_pcie_tx_pkt_fifo.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_tx_pkt_fifo_pkg.sv
// Shared types and constants for the PCIe TX store-and-forward packet FIFO.
package pcie_tx_pkt_fifo_pkg;

   localparam int PCIE_TX_PKT_FIFO_DEPTH = 512;

   localparam int TDATA_W = 512;
   localparam int TKEEP_W = TDATA_W / 8;
   localparam int TUSER_W = 10;

   // One stored beat; all sideband travels with its data word.
   typedef struct packed {
      logic [TUSER_W-1:0] tuser_vendor;
      logic               tlast;
      logic [TKEEP_W-1:0] tkeep;
      logic [TDATA_W-1:0] tdata;
   } t_tx_fifo_entry;

   // Forwarding mode: normal store-and-forward, or cut-through for oversized TLPs.
   typedef enum logic {
      FWD_STORE = 1'b0,
      FWD_CUT   = 1'b1
   } t_fwd_mode;

endpackage

// File: rtl/pcie_tx_pkt_fifo_if.sv
// AXI-Stream bundle used on both sides of the PCIe TX packet FIFO.
interface pcie_tx_pkt_fifo_if;
   import pcie_tx_pkt_fifo_pkg::*;

   // Handshake: a beat transfers on a rising clk edge where tvalid & tready are both 1.
   // The master must hold tvalid and all payload stable until that transfer happens;
   // tready may change freely and never depends combinationally on tvalid in this block.
   logic               tvalid;
   logic               tready;
   logic [TDATA_W-1:0] tdata;
   logic [TKEEP_W-1:0] tkeep;
   logic               tlast;
   logic [TUSER_W-1:0] tuser_vendor;

   modport master (
      output tvalid, tdata, tkeep, tlast, tuser_vendor,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tkeep, tlast, tuser_vendor,
      output tready
   );

endinterface

// File: rtl/pcie_tx_pkt_fifo_mem.sv
// Simple dual-port beat storage with a one-cycle registered read port.
module pcie_tx_pkt_fifo_mem
   import pcie_tx_pkt_fifo_pkg::*;
#(
   parameter int DEPTH  = PCIE_TX_PKT_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  t_tx_fifo_entry    wdata,
   input  logic [ADDR_W-1:0] raddr,
   output t_tx_fifo_entry    rdata
);

   t_tx_fifo_entry mem [DEPTH];

   // Write and read every cycle; a read of the address being written returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/pcie_tx_pkt_fifo.sv
// Store-and-forward TLP FIFO in front of the PCIe SS TX port, with a
// cut-through fallback for TLPs larger than the buffer.
module pcie_tx_pkt_fifo
   import pcie_tx_pkt_fifo_pkg::*;
#(
   parameter  int DEPTH  = PCIE_TX_PKT_FIFO_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   pcie_tx_pkt_fifo_if.slave   i_tx_st,
   pcie_tx_pkt_fifo_if.master  o_tx_st,
   output logic [ADDR_W:0]     o_fill_level,
   output logic [ADDR_W:0]     o_pkt_cnt,
   output logic                o_cut_through
);

   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

   logic [ADDR_W:0] wr_ptr_q, wr_ptr_nxt;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_nxt;
   logic [ADDR_W:0] fill_q, fill_nxt;
   logic [ADDR_W:0] pkt_cnt_q, pkt_cnt_nxt;
   logic            tready_q;
   logic            full_nxt;
   t_fwd_mode       mode_q, mode_nxt;

   t_tx_fifo_entry  wr_entry;
   t_tx_fifo_entry  mem_rdata;
   t_tx_fifo_entry  head_byp_q;
   t_tx_fifo_entry  head;
   logic            head_sel_q;

   logic            wr_en;
   logic            pop;
   logic            out_valid;
   logic            head_loaded;
   logic            wr_last;
   logic            pop_last;
   logic            byp_load;

   assign wr_entry = '{tuser_vendor: i_tx_st.tuser_vendor,
                       tlast:        i_tx_st.tlast,
                       tkeep:        i_tx_st.tkeep,
                       tdata:        i_tx_st.tdata};

   assign wr_en      = i_tx_st.tvalid & tready_q;
   assign wr_last    = wr_en & i_tx_st.tlast;

   // The RAM output register always holds the word at rd_ptr, except when that word
   // was written on the previous edge; then the bypass copy is the live head.
   assign head        = head_sel_q ? head_byp_q : mem_rdata;
   assign head_loaded = (fill_q != '0);
   assign out_valid   = head_loaded & ((pkt_cnt_q != '0) | (mode_q == FWD_CUT));
   assign pop         = out_valid & o_tx_st.tready;
   assign pop_last    = pop & head.tlast;

   assign wr_ptr_nxt = wr_ptr_q + (wr_en ? ONE : '0);
   assign rd_ptr_nxt = rd_ptr_q + (pop   ? ONE : '0);
   assign full_nxt   = (wr_ptr_nxt[ADDR_W] != rd_ptr_nxt[ADDR_W]) &&
                       (wr_ptr_nxt[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);

   // A write landing on the slot the read port fetches this edge would read stale data.
   assign byp_load = wr_en & (wr_ptr_q[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);

   pcie_tx_pkt_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (wr_entry),
      .raddr (rd_ptr_nxt[ADDR_W-1:0]),
      .rdata (mem_rdata)
   );

   // Beat and packet counters, and the forwarding-mode transition.
   always_comb begin
      fill_nxt    = fill_q;
      pkt_cnt_nxt = pkt_cnt_q;
      mode_nxt    = mode_q;

      if (wr_en && !pop) begin
         fill_nxt = fill_q + ONE;
      end else if (!wr_en && pop) begin
         fill_nxt = fill_q - ONE;
      end

      if (wr_last && !pop_last) begin
         pkt_cnt_nxt = pkt_cnt_q + ONE;
      end else if (!wr_last && pop_last) begin
         pkt_cnt_nxt = pkt_cnt_q - ONE;
      end

      case (mode_q)
         FWD_STORE: begin
            // Buffer full with no complete TLP inside: waiting would deadlock.
            if (fill_q == FULL_LVL && pkt_cnt_q == '0) begin
               mode_nxt = FWD_CUT;
            end
         end
         FWD_CUT: begin
            if (pop_last) begin
               mode_nxt = FWD_STORE;
            end
         end
         default: mode_nxt = FWD_STORE;
      endcase
   end

   // Control state: pointers, counters, registered tready, mode and head select.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         pkt_cnt_q  <= '0;
         tready_q   <= 1'b0;
         mode_q     <= FWD_STORE;
         head_sel_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_nxt;
         rd_ptr_q   <= rd_ptr_nxt;
         fill_q     <= fill_nxt;
         pkt_cnt_q  <= pkt_cnt_nxt;
         tready_q   <= !full_nxt;
         mode_q     <= mode_nxt;
         head_sel_q <= byp_load;
      end
   end

   // Bypass copy of a beat written straight into the head slot.
   always_ff @(posedge clk) begin
      if (byp_load) begin
         head_byp_q <= wr_entry;
      end
   end

   assign i_tx_st.tready       = tready_q;

   assign o_tx_st.tvalid       = out_valid;
   assign o_tx_st.tdata        = head.tdata;
   assign o_tx_st.tkeep        = head.tkeep;
   assign o_tx_st.tlast        = head.tlast;
   assign o_tx_st.tuser_vendor = head.tuser_vendor;

   assign o_fill_level  = fill_q;
   assign o_pkt_cnt     = pkt_cnt_q;
   assign o_cut_through = (mode_q == FWD_CUT);

endmodule

// File: tb/tb_pcie_tx_pkt_fifo.sv
// Directed and randomized bench for pcie_tx_pkt_fifo against a queue-based model.
module tb_pcie_tx_pkt_fifo;
   import pcie_tx_pkt_fifo_pkg::*;

   localparam int DEPTH = PCIE_TX_PKT_FIFO_DEPTH;
   localparam int AW    = $clog2(DEPTH);
   localparam int EW    = $bits(t_tx_fifo_entry);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pcie_tx_pkt_fifo_if in_if ();
   pcie_tx_pkt_fifo_if out_if ();

   logic [AW:0] o_fill_level;
   logic [AW:0] o_pkt_cnt;
   logic        o_cut_through;

   pcie_tx_pkt_fifo dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_tx_st       (in_if),
      .o_tx_st       (out_if),
      .o_fill_level  (o_fill_level),
      .o_pkt_cnt     (o_pkt_cnt),
      .o_cut_through (o_cut_through)
   );

   // ---------------- model / scoreboard state ----------------
   logic [EW-1:0]  exp_q[$];      // beats accepted by the FIFO, not yet popped
   t_tx_fifo_entry src_q[$];      // beats still to be offered by the source
   int             model_pkts;    // complete TLPs inside the FIFO
   bit             ct_model;
   bit             prev_elig, prev_hold, in_acc;
   logic [EW-1:0]  prev_beat;
   int             hi_edges;      // clean edges since reset released
   int             in_pct, out_pct;
   int             cyc, first_pop, last_pop, last_wr, pops, max_pkt, fill_at_ct;
   bit             ct_seen;
   int             checks = 0;
   int             errors = 0;

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic t_tx_fifo_entry make_beat(input bit last);
      t_tx_fifo_entry b;
      for (int i = 0; i < TDATA_W / 32; i++) b.tdata[i*32 +: 32] = $urandom();
      b.tkeep        = {$urandom(), $urandom()};
      b.tuser_vendor = TUSER_W'($urandom());
      b.tlast        = last;
      return b;
   endfunction

   task automatic queue_tlp(input int n);
      for (int i = 0; i < n; i++) src_q.push_back(make_beat(i == n - 1));
   endtask

   task automatic mark();
      first_pop = -1;
      last_pop  = -1;
      pops      = 0;
      max_pkt   = 0;
      ct_seen   = 0;
      fill_at_ct = -1;
   endtask

   // Compare DUT against the model at mid-cycle, then advance the model by this cycle's transfers.
   task automatic sample();
      bit             wr, rd, elig, ct_next;
      logic [EW-1:0]  ob;
      t_tx_fifo_entry h;
      cyc++;
      if (!rst_n) return;
      wr = (in_if.tvalid === 1'b1) && (in_if.tready === 1'b1);
      rd = (out_if.tvalid === 1'b1) && (out_if.tready === 1'b1);
      ob = {out_if.tuser_vendor, out_if.tlast, out_if.tkeep, out_if.tdata};

      check("fill_level", EW'(o_fill_level), EW'(exp_q.size()));
      check("pkt_cnt", EW'(o_pkt_cnt), EW'(model_pkts));
      check("cut_through", EW'(o_cut_through), EW'(ct_model));
      if (hi_edges == 0) begin
         check("tready_after_reset", EW'(in_if.tready), EW'(0));
         check("tvalid_after_reset", EW'(out_if.tvalid), EW'(0));
      end else begin
         check("tready", EW'(in_if.tready), EW'(exp_q.size() < DEPTH));
      end

      elig = (exp_q.size() > 0) && (model_pkts > 0 || ct_model);
      if (!elig) check("tvalid_not_eligible", EW'(out_if.tvalid), EW'(0));
      else if (prev_elig) check("tvalid_late_or_bubble", EW'(out_if.tvalid), EW'(1));
      if (prev_hold) begin
         check("hold_valid", EW'(out_if.tvalid), EW'(1));
         check("hold_data", ob, prev_beat);
      end

      if (o_pkt_cnt > max_pkt) max_pkt = o_pkt_cnt;
      if (o_cut_through === 1'b1 && !ct_seen) begin
         ct_seen    = 1;
         fill_at_ct = o_fill_level;
      end

      ct_next = ct_model;
      if (rd && exp_q.size() == 0) begin
         check("pop_when_empty", EW'(rd), EW'(0));
      end else if (rd) begin
         check("beat", ob, exp_q[0]);
         h = exp_q.pop_front();
         if (h.tlast) model_pkts--;
         if (ct_model && h.tlast) ct_next = 0;
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      if (!ct_model && (exp_q.size() + (rd ? 1 : 0)) == DEPTH && (model_pkts + ((rd && h.tlast) ? 1 : 0)) == 0)
         ct_next = 1;
      ct_model = ct_next;

      if (wr) begin
         exp_q.push_back({in_if.tuser_vendor, in_if.tlast, in_if.tkeep, in_if.tdata});
         if (in_if.tlast) begin
            model_pkts++;
            last_wr = cyc;
         end
         void'(src_q.pop_front());
         in_acc = 1;
      end
      prev_elig = elig;
      prev_hold = (out_if.tvalid === 1'b1) && (out_if.tready !== 1'b1);
      prev_beat = ob;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive();
      if (!rst_n) begin
         in_if.tvalid = 1'b0;
      end else if (!(in_if.tvalid && !in_acc)) begin
         if (src_q.size() > 0 && $urandom_range(99) < in_pct) begin
            in_if.tvalid       = 1'b1;
            in_if.tdata        = src_q[0].tdata;
            in_if.tkeep        = src_q[0].tkeep;
            in_if.tlast        = src_q[0].tlast;
            in_if.tuser_vendor = src_q[0].tuser_vendor;
         end else begin
            in_if.tvalid = 1'b0;
         end
      end
      in_acc = 0;
      out_if.tready = ($urandom_range(99) < out_pct);
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      if (rst_n) hi_edges++;
      #1;
      drive();
   endtask

   task automatic apply_reset(input int n);
      rst_n        = 1'b0;
      in_if.tvalid = 1'b0;
      src_q.delete();
      exp_q.delete();
      model_pkts = 0;
      ct_model   = 0;
      prev_elig  = 0;
      prev_hold  = 0;
      in_acc     = 0;
      hi_edges   = 0;
      repeat (n) step();
      rst_n = 1'b1;
   endtask

   task automatic wait_src(input int budget);
      int n = 0;
      while (src_q.size() > 0 && n < budget) begin
         step();
         n++;
      end
      check("src_timeout", EW'(src_q.size()), EW'(0));
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         step();
         n++;
      end
      check("drain_timeout", EW'(src_q.size() + exp_q.size()), EW'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      in_if.tvalid = 1'b0;
      in_if.tdata  = '0;
      in_if.tkeep  = '0;
      in_if.tlast  = 1'b0;
      in_if.tuser_vendor = '0;
      out_if.tready = 1'b0;
      in_pct = 100;
      out_pct = 100;
      cyc = 0;
      last_wr = 0;
      mark();
      @(posedge clk);
      #1;
      apply_reset(3);

      // 3-beat TLP, sink always ready
      mark();
      queue_tlp(3);
      drain(100);
      check("t1_sop_latency", EW'((first_pop - last_wr) inside {[1:2]}), EW'(1));
      check("t1_contiguous", EW'(last_pop - first_pop), EW'(2));
      check("t1_pops", EW'(pops), EW'(3));

      // 4-beat TLP with a 5-cycle source stall after beat 1
      mark();
      src_q.push_back(make_beat(1'b0));
      wait_src(20);
      repeat (5) step();
      src_q.push_back(make_beat(1'b0));
      src_q.push_back(make_beat(1'b0));
      src_q.push_back(make_beat(1'b1));
      drain(100);
      check("t2_contiguous", EW'(last_pop - first_pop), EW'(3));
      check("t2_pops", EW'(pops), EW'(4));
      check("t2_max_pkt_cnt", EW'(max_pkt), EW'(1));

      // fill with 512 single-beat TLPs while sink is stalled, then drain
      out_pct = 0;
      mark();
      for (int i = 0; i < DEPTH; i++) queue_tlp(1);
      wait_src(DEPTH + 100);
      step();
      check("t3_tready_full", EW'(in_if.tready), EW'(0));
      check("t3_fill_full", EW'(o_fill_level), EW'(DEPTH));
      check("t3_pkt_full", EW'(o_pkt_cnt), EW'(DEPTH));
      out_pct = 100;
      drain(DEPTH + 100);
      step();
      check("t3_back_to_back", EW'(last_pop - first_pop), EW'(DEPTH - 1));
      check("t3_pops", EW'(pops), EW'(DEPTH));
      check("t3_fill_empty", EW'(o_fill_level), EW'(0));

      // oversized TLP forces cut-through
      mark();
      queue_tlp(600);
      drain(3000);
      step();
      check("t4_ct_seen", EW'(ct_seen), EW'(1));
      check("t4_fill_at_ct", EW'(fill_at_ct), EW'(DEPTH));
      check("t4_pops", EW'(pops), EW'(600));
      check("t4_ct_cleared", EW'(o_cut_through), EW'(0));
      mark();
      queue_tlp(2);
      drain(100);
      check("t4_sf_latency", EW'((first_pop - last_wr) inside {[1:2]}), EW'(1));
      check("t4_sf_contiguous", EW'(last_pop - first_pop), EW'(1));
      check("t4_no_ct", EW'(ct_seen), EW'(0));

      // randomized traffic, 50% valid / 50% ready
      in_pct = 50;
      out_pct = 50;
      mark();
      for (int i = 0; i < 300; i++) queue_tlp($urandom_range(1, 16));
      drain(40000);

      // reset with 2.5 TLPs buffered
      in_pct = 100;
      out_pct = 0;
      queue_tlp(4);
      queue_tlp(4);
      src_q.push_back(make_beat(1'b0));
      src_q.push_back(make_beat(1'b0));
      wait_src(100);
      step();
      check("t6_fill_before_reset", EW'(o_fill_level), EW'(10));
      check("t6_pkt_before_reset", EW'(o_pkt_cnt), EW'(2));
      apply_reset(1);
      step();
      out_pct = 100;
      mark();
      queue_tlp(3);
      drain(200);
      check("t6_next_tlp_pops", EW'(pops), EW'(3));
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
